// File: rtl/mips_isa_pkg.sv
// MIPS opcode/funct encodings, symbolic instruction kinds and word-packing helpers.
// Shared between the instruction loader and the control decoder.
package mips_isa_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned KIND_W  = 4;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'h2A;

  typedef enum logic [KIND_W-1:0] {
    KIND_ADD  = 4'd0,
    KIND_SUB  = 4'd1,
    KIND_AND  = 4'd2,
    KIND_OR   = 4'd3,
    KIND_SLT  = 4'd4,
    KIND_ADDI = 4'd5,
    KIND_LW   = 4'd6,
    KIND_SW   = 4'd7,
    KIND_BEQ  = 4'd8
  } kind_e;

  typedef struct packed {
    logic [KIND_W-1:0] kind;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [IMM_W-1:0]  imm;
  } instr_sym_t;

  // Kinds above BEQ have no encoding.
  function automatic logic kind_illegal(input logic [KIND_W-1:0] kind);
    return kind > KIND_W'(KIND_BEQ);
  endfunction

  function automatic logic [WORD_W-1:0] r_word(input instr_sym_t sym,
                                               input logic [FUNCT_W-1:0] funct);
    return {OP_RTYPE, sym.rs, sym.rt, sym.rd, 5'b0, funct};
  endfunction

  function automatic logic [WORD_W-1:0] i_word(input instr_sym_t sym,
                                               input logic [OP_W-1:0] op);
    return {op, sym.rs, sym.rt, sym.imm};
  endfunction

endpackage

// File: rtl/instr_word_encode.sv
// Combinational packer: symbolic instruction -> 32-bit MIPS word plus illegal-kind flag.
module instr_word_encode
  import mips_isa_pkg::*;
(
  input  instr_sym_t          instr_i,
  output logic [WORD_W-1:0]   word_c_o,
  output logic                illegal_c_o
);

  always_comb begin
    word_c_o    = '0;
    illegal_c_o = kind_illegal(instr_i.kind);
    case (instr_i.kind)
      KIND_ADD:  word_c_o = r_word(instr_i, FUNCT_ADD);
      KIND_SUB:  word_c_o = r_word(instr_i, FUNCT_SUB);
      KIND_AND:  word_c_o = r_word(instr_i, FUNCT_AND);
      KIND_OR:   word_c_o = r_word(instr_i, FUNCT_OR);
      KIND_SLT:  word_c_o = r_word(instr_i, FUNCT_SLT);
      KIND_ADDI: word_c_o = i_word(instr_i, OP_ADDI);
      KIND_LW:   word_c_o = i_word(instr_i, OP_LW);
      KIND_SW:   word_c_o = i_word(instr_i, OP_SW);
      KIND_BEQ:  word_c_o = i_word(instr_i, OP_BEQ);
      default:   word_c_o = '0;
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Accepts symbolic instructions over valid/ready, encodes them and writes one word
// per cycle into instruction memory at consecutive addresses.
module instr_encode_loader
  import mips_isa_pkg::*;
#(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [KIND_W-1:0]   in_kind,
  input  logic [REG_W-1:0]    in_rs,
  input  logic [REG_W-1:0]    in_rt,
  input  logic [REG_W-1:0]    in_rd,
  input  logic [IMM_W-1:0]    in_imm,
  input  logic                in_last,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [WORD_W-1:0]   imem_wdata,
  output logic [ADDR_W:0]     count,
  output logic                full,
  output logic                done,
  output logic                err_illegal
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  CAPACITY = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  typedef enum logic {ST_LOAD, ST_DONE} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                full_q, full_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  instr_sym_t          sym;
  logic [WORD_W-1:0]   enc_word;
  logic                enc_illegal;
  logic                accept;

  assign sym = '{kind: in_kind, rs: in_rs, rt: in_rt, rd: in_rd, imm: in_imm};

  instr_word_encode u_encode (
    .instr_i     (sym),
    .word_c_o    (enc_word),
    .illegal_c_o (enc_illegal)
  );

  // Ready depends only on registers and the restart inputs, never on in_valid.
  assign in_ready = (state_q == ST_LOAD) & ~full_q & ~reset & ~clear;
  assign accept   = in_valid & in_ready;

  // Count and full advance at accept so full blocks the very next handshake;
  // the address advances as each word leaves the output register.
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = we_q ? addr_q + ADDR_W'(1) : addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    full_d  = full_q;
    done_d  = done_q;
    err_d   = err_q;

    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          if (enc_illegal) begin
            err_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            wdata_d = enc_word;
            count_d = count_q + CNT_W'(1);
            full_d  = (count_q + CNT_W'(1)) == CAPACITY;
          end
          if (in_last) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_LOAD;
    endcase

    if (clear) begin
      state_d = ST_LOAD;
      we_d    = 1'b0;
      addr_d  = BASE;
      wdata_d = '0;
      count_d = '0;
      full_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_LOAD;
      we_q    <= 1'b0;
      addr_q  <= BASE;
      wdata_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      full_q  <= full_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign count       = count_q;
  assign full        = full_q;
  assign done        = done_q;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed self-checking bench: a default-size loader and a 4-word loader for the full case.
module tb_instr_encode_loader;

  logic        clk = 1'b0;
  logic        reset, clear, clear2;
  logic        in_valid, in_valid2, in_last;
  logic [3:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;

  logic        ready1, we1, full1, done1, err1;
  logic [5:0]  addr1;
  logic [31:0] wdata1;
  logic [6:0]  count1;

  logic        ready2, we2, full2, done2, err2;
  logic [1:0]  addr2;
  logic [31:0] wdata2;
  logic [2:0]  count2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_encode_loader #(.ADDR_W(6), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(ready1), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_last(in_last),
    .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1),
    .count(count1), .full(full1), .done(done1), .err_illegal(err1)
  );

  instr_encode_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
    .clk(clk), .reset(reset), .clear(clear2),
    .in_valid(in_valid2), .in_ready(ready2), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_last(in_last),
    .imem_we(we2), .imem_addr(addr2), .imem_wdata(wdata2),
    .count(count2), .full(full2), .done(done2), .err_illegal(err2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm);
    in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
  endtask

  logic [3:0]  s_kind [4];
  logic [4:0]  s_rs   [4];
  logic [4:0]  s_rt   [4];
  logic [15:0] s_imm  [4];
  logic [31:0] s_exp  [4];

  initial begin
    reset = 1'b1; clear = 1'b0; clear2 = 1'b0;
    in_valid = 1'b0; in_valid2 = 1'b0; in_last = 1'b0;
    drive(4'd0, 5'd0, 5'd0, 5'd0, 16'd0);
    step(); step();

    chk("rst_we",    64'(we1), 64'd0);
    chk("rst_addr",  64'(addr1), 64'd0);
    chk("rst_wdata", 64'(wdata1), 64'd0);
    chk("rst_count", 64'(count1), 64'd0);
    chk("rst_flags", 64'({full1, done1, err1}), 64'd0);
    chk("rst_ready", 64'(ready1), 64'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", 64'(ready1), 64'd1);

    // Single add
    drive(4'd0, 5'd1, 5'd2, 5'd3, 16'd0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("add_we",    64'(we1), 64'd1);
    chk("add_addr",  64'(addr1), 64'd0);
    chk("add_wdata", 64'(wdata1), 64'h00221820);
    chk("add_count", 64'(count1), 64'd1);
    step();
    chk("add_we_drop", 64'(we1), 64'd0);

    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_addr",  64'(addr1), 64'd0);
    chk("clr_count", 64'(count1), 64'd0);

    // Back-to-back stream lw/sw/beq/addi
    s_kind[0] = 4'd6; s_rs[0] = 5'd0; s_rt[0] = 5'd2; s_imm[0] = 16'h0004; s_exp[0] = 32'h8C020004;
    s_kind[1] = 4'd7; s_rs[1] = 5'd1; s_rt[1] = 5'd2; s_imm[1] = 16'h0008; s_exp[1] = 32'hAC220008;
    s_kind[2] = 4'd8; s_rs[2] = 5'd1; s_rt[2] = 5'd2; s_imm[2] = 16'hFFFF; s_exp[2] = 32'h1022FFFF;
    s_kind[3] = 4'd5; s_rs[3] = 5'd0; s_rt[3] = 5'd5; s_imm[3] = 16'h0007; s_exp[3] = 32'h20050007;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(s_kind[i], s_rs[i], s_rt[i], 5'd31, s_imm[i]);
      step();
      chk($sformatf("stream_we%0d", i),    64'(we1), 64'd1);
      chk($sformatf("stream_addr%0d", i),  64'(addr1), 64'(i));
      chk($sformatf("stream_wdata%0d", i), 64'(wdata1), 64'(s_exp[i]));
    end
    in_valid = 1'b0;
    step();
    chk("stream_count", 64'(count1), 64'd4);
    chk("stream_idle",  64'(we1), 64'd0);
    chk("stream_next_addr", 64'(addr1), 64'd4);

    // Illegal kind mid-stream
    drive(4'd12, 5'd1, 5'd2, 5'd3, 16'h1234);
    in_valid = 1'b1;
    step();
    chk("ill_err",   64'(err1), 64'd1);
    chk("ill_no_we", 64'(we1), 64'd0);
    chk("ill_count", 64'(count1), 64'd4);
    drive(4'd0, 5'd1, 5'd2, 5'd3, 16'd0);
    step();
    chk("post_ill_we",    64'(we1), 64'd1);
    chk("post_ill_addr",  64'(addr1), 64'd4);
    chk("post_ill_wdata", 64'(wdata1), 64'h00221820);
    chk("post_ill_count", 64'(count1), 64'd5);

    // slt with in_last, then held valid
    drive(4'd4, 5'd1, 5'd2, 5'd4, 16'd0);
    in_last = 1'b1;
    step();
    chk("last_we",    64'(we1), 64'd1);
    chk("last_addr",  64'(addr1), 64'd5);
    chk("last_wdata", 64'(wdata1), 64'h0022202A);
    chk("last_done",  64'(done1), 64'd1);
    chk("last_ready", 64'(ready1), 64'd0);
    step();
    chk("done_hold_we", 64'(we1), 64'd0);
    step();
    chk("done_hold_we2",   64'(we1), 64'd0);
    chk("done_hold_count", 64'(count1), 64'd6);
    chk("done_err_sticky", 64'(err1), 64'd1);
    clear = 1'b1;
    #1;
    chk("clear_blocks_ready", 64'(ready1), 64'd0);
    step();
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    #1;
    chk("clr2_addr",  64'(addr1), 64'd0);
    chk("clr2_done",  64'(done1), 64'd0);
    chk("clr2_err",   64'(err1), 64'd0);
    chk("clr2_count", 64'(count1), 64'd0);
    chk("clr2_we",    64'(we1), 64'd0);
    chk("clr2_ready", 64'(ready1), 64'd1);

    // 4-word loader fills, 5th word held
    drive(4'd0, 5'd1, 5'd2, 5'd3, 16'd0);
    in_valid2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("fill_we%0d", i),    64'(we2), 64'd1);
      chk($sformatf("fill_addr%0d", i),  64'(addr2), 64'(i));
      chk($sformatf("fill_count%0d", i), 64'(count2), 64'(i + 1));
    end
    chk("fill_full",  64'(full2), 64'd1);
    chk("fill_ready", 64'(ready2), 64'd0);
    step();
    chk("fill_5th_no_we", 64'(we2), 64'd0);
    chk("fill_wrap_addr", 64'(addr2), 64'd0);
    chk("fill_count_hold", 64'(count2), 64'd4);
    in_valid2 = 1'b0;
    clear2 = 1'b1;
    step();
    clear2 = 1'b0;
    chk("fill_clr_full",  64'(full2), 64'd0);
    chk("fill_clr_count", 64'(count2), 64'd0);

    // in_last on the word that fills the memory
    in_valid2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_last = (i == 3);
      step();
    end
    in_valid2 = 1'b0; in_last = 1'b0;
    chk("lastfull_full", 64'(full2), 64'd1);
    chk("lastfull_done", 64'(done2), 64'd1);
    chk("lastfull_we",   64'(we2), 64'd1);
    chk("lastfull_addr", 64'(addr2), 64'd3);

    // Reset in the cycle after an accept cancels the write
    drive(4'd1, 5'd1, 5'd2, 5'd3, 16'd0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("pre_rst_we", 64'(we1), 64'd1);
    reset = 1'b1;
    #1;
    chk("rst_ready_low", 64'(ready1), 64'd0);
    step();
    chk("rst2_we",    64'(we1), 64'd0);
    chk("rst2_addr",  64'(addr1), 64'd0);
    chk("rst2_wdata", 64'(wdata1), 64'd0);
    chk("rst2_count", 64'(count1), 64'd0);
    chk("rst2_flags", 64'({full1, done1, err1}), 64'd0);
    chk("rst2_dut2",  64'({full2, done2, count2}), 64'd0);
    reset = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
